gba_dump_controller: RTL and testbench
======================================

// Module: gba_dump_controller
// PURPOSE
//  Host-command sequencer for the GBA pak reader. Decodes host bytes from the UART RX side,
//  programs cartridgeSize, pulses startDump and frames the dump (header, data, XOR trailer).
//  Arbitrates the single UART TX byte channel between its own reply bytes and the reader's
//  data bytes. Sits between the UART RX/TX modules and the pak reader.
// PARAMETERS
//  VERSION        8'h01   byte returned for the 'V' command
//  START_TIMEOUT  1024    cycles allowed for reader_DumpCompleted to fall after startDump
// PORTS
//  clk                    in   1  system clock
//  rst                    in   1  asynchronous, active-high reset
//  rx_Data                in   8  host byte
//  rx_Valid               in   1  one-cycle strobe, rx_Data valid
//  tx_Data                out  8  byte to UART TX
//  tx_Send                out  1  one-cycle strobe, tx_Data valid
//  tx_IsReady             in   1  UART TX can accept a byte
//  reader_CartridgeSize   out  4  size code to the reader (0 = header only, n = n*4 MiB)
//  reader_StartDump       out  1  one-cycle start pulse
//  reader_DumpCompleted   in   1  reader idle
//  reader_Data            in   8  reader data byte
//  reader_Send            in   1  reader byte strobe
//  reader_IsReady         out  1  TX ready as seen by the reader
//  busy                   out  1  high in every state except IDLE
//  error                  out  1  sticky; set by timeout or bad argument; cleared by the next valid command
// BEHAVIOUR
//  Reset values: tx_Data=0, tx_Send=0, reader_StartDump=0, reader_CartridgeSize=0, error=0.
//  Reset forces state RESYNC. rst does not reach the reader.
//  Commands, first byte:
//   'V'(0x56) -> reply VERSION
//   'D'(0x44) -> next byte is the size argument
//   anything else -> reply 'E'(0x45)
//  Size argument with upper nibble != 0 -> reply 'E' and set error.
//  States:
//   RESYNC:    wait for reader_DumpCompleted=1 -> IDLE. Drops rx_Valid.
//   IDLE:      'V' -> REPLY. 'D' -> WAIT_ARG. Other byte -> REPLY('E').
//   WAIT_ARG:  next rx_Valid. Valid argument: latch size, clear xor/count -> HDR0. Bad -> REPLY('E').
//   HDR0/HDR1: send 0xA5, then {4'h0,size}. Each byte waits for tx_IsReady.
//   START:     reader_StartDump=1 for exactly 1 cycle -> ARMED.
//   ARMED:     wait for reader_DumpCompleted=0 -> STREAM. Timeout counter hits START_TIMEOUT
//              -> error=1, REPLY('E').
//   STREAM:    tx_Data=reader_Data, tx_Send=reader_Send, combinational pass-through, 0 added latency.
//              xor ^= reader_Data on each reader_Send. reader_DumpCompleted=1 -> TRL0.
//   TRL0/TRL1: send 0x5A, then the xor byte -> IDLE.
//   REPLY:     send one byte -> IDLE.
//  reader_IsReady = tx_IsReady in STREAM, else 0. The reader must never emit outside STREAM.
//  The controller drives tx_Send only when tx_IsReady=1, one byte per pulse. tx_Send is
//  deasserted the cycle after each controller-owned byte.
//  rx_Valid in any state other than IDLE/WAIT_ARG is dropped. No queueing.
//  Simultaneous tx_IsReady drop and pending byte: hold the byte until ready returns.
//  Timeout counter: 11 bits, saturating, cleared on entry to ARMED.
//  xor register: 8 bits, cleared in WAIT_ARG.
// STRUCTURE
//  Shared package gba_pkg: command codes (CMD_VERSION, CMD_DUMP), framing bytes
//  (HDR_MAGIC=8'hA5, TRL_MAGIC=8'h5A, RSP_ERR=8'h45), state encoding localparams.
//  One natural sub-module: gba_tx_arbiter (2:1 TX mux with ready gating, owner select from FSM).
//  FSM, timeout counter and xor stay in this module.
// TESTING
//  1. rx 'V', tx_IsReady=1 -> single tx_Send with tx_Data=8'h01, busy returns 0.
//  2. rx 'D',0x00, reader model with 192 bytes of 0x11 -> tx: A5,00, 192 x 11, 5A,00;
//     exactly one reader_StartDump pulse.
//  3. rx 'D',0x13 -> tx 0x45, error=1, no reader_StartDump. Then rx 'V' -> tx 0x01, error=0.
//  4. Reader model never drops DumpCompleted -> after 1024 cycles, error=1, tx 0x45, IDLE.
//  5. Toggle tx_IsReady every 3 cycles during test 2 -> same byte sequence, no lost or duplicated bytes.
//  6. Assert rst mid-STREAM while the reader model continues -> RESYNC, no tx_Send and
//     reader_IsReady=0 until DumpCompleted=1, then 'V' is answered normally.

Source files
------------

// File: rtl/gba_pkg.sv
// Shared definitions for the GBA pak dump controller: host command codes, framing bytes,
// sequencer state encoding and a small saturating-counter helper.
package gba_pkg;

    localparam logic [7:0] CMD_VERSION = 8'h56;
    localparam logic [7:0] CMD_DUMP    = 8'h44;
    localparam logic [7:0] HDR_MAGIC   = 8'hA5;
    localparam logic [7:0] TRL_MAGIC   = 8'h5A;
    localparam logic [7:0] RSP_ERR     = 8'h45;

    localparam int TIMEOUT_W = 11;

    typedef enum logic [3:0] {
        ST_RESYNC   = 4'd0,
        ST_IDLE     = 4'd1,
        ST_WAIT_ARG = 4'd2,
        ST_HDR0     = 4'd3,
        ST_HDR1     = 4'd4,
        ST_START    = 4'd5,
        ST_ARMED    = 4'd6,
        ST_STREAM   = 4'd7,
        ST_TRL0     = 4'd8,
        ST_TRL1     = 4'd9,
        ST_REPLY    = 4'd10
    } gba_state_e;

    function automatic logic [TIMEOUT_W-1:0] sat_inc(input logic [TIMEOUT_W-1:0] v);
        logic [TIMEOUT_W-1:0] r;
        if (v == {TIMEOUT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/gba_tx_arbiter.sv
// 2:1 UART TX byte mux. The reader owns the channel during streaming (zero-latency
// pass-through); otherwise the controller's pending byte goes out when TX is ready.
module gba_tx_arbiter (
    input  logic       owner_reader,
    input  logic [7:0] ctl_data,
    input  logic       ctl_pending,
    input  logic [7:0] reader_data,
    input  logic       reader_send,
    input  logic       tx_is_ready,
    output logic [7:0] tx_data,
    output logic       tx_send,
    output logic       reader_is_ready,
    output logic       ctl_accept
);

    // Owner select and ready gating
    always_comb begin
        tx_data         = ctl_data;
        tx_send         = 1'b0;
        reader_is_ready = 1'b0;
        ctl_accept      = 1'b0;
        if (owner_reader) begin
            tx_data         = reader_data;
            tx_send         = reader_send;
            reader_is_ready = tx_is_ready;
        end else begin
            tx_send    = ctl_pending & tx_is_ready;
            ctl_accept = ctl_pending & tx_is_ready;
        end
    end

endmodule

// File: rtl/gba_dump_controller.sv
// Host-command sequencer for the GBA pak reader: decodes host commands, frames the dump
// with a header and XOR trailer, and shares the UART TX channel with the reader.
module gba_dump_controller
    import gba_pkg::*;
#(
    parameter logic [7:0] VERSION       = 8'h01,
    parameter int         START_TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_Data,
    input  logic       rx_Valid,
    output logic [7:0] tx_Data,
    output logic       tx_Send,
    input  logic       tx_IsReady,
    output logic [3:0] reader_CartridgeSize,
    output logic       reader_StartDump,
    input  logic       reader_DumpCompleted,
    input  logic [7:0] reader_Data,
    input  logic       reader_Send,
    output logic       reader_IsReady,
    output logic       busy,
    output logic       error
);

    localparam logic [TIMEOUT_W-1:0] TIMEOUT_CNT = TIMEOUT_W'(START_TIMEOUT);

    gba_state_e           state_q, state_d;
    logic                 pend_q, pend_d;
    logic [7:0]           pend_data_q, pend_data_d;
    logic                 start_q, start_d;
    logic [3:0]           size_q, size_d;
    logic                 error_q, error_d;
    logic [7:0]           xor_q, xor_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic [7:0]           reply_q, reply_d;
    logic                 busy_q, busy_d;
    logic                 ctl_accept_s;
    logic                 owner_reader_s;
    logic                 timeout_s;

    assign owner_reader_s = (state_q == ST_STREAM);
    assign timeout_s      = (cnt_q == TIMEOUT_CNT);

    gba_tx_arbiter u_arb (
        .owner_reader    (owner_reader_s),
        .ctl_data        (pend_data_q),
        .ctl_pending     (pend_q),
        .reader_data     (reader_Data),
        .reader_send     (reader_Send),
        .tx_is_ready     (tx_IsReady),
        .tx_data         (tx_Data),
        .tx_send         (tx_Send),
        .reader_is_ready (reader_IsReady),
        .ctl_accept      (ctl_accept_s)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RESYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; byte-sending states advance only once the previous byte has left
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESYNC: begin
                if (reader_DumpCompleted) state_d = ST_IDLE;
                else                      state_d = ST_RESYNC;
            end
            ST_IDLE: begin
                if (rx_Valid) begin
                    if (rx_Data == CMD_DUMP) state_d = ST_WAIT_ARG;
                    else                     state_d = ST_REPLY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_ARG: begin
                if (rx_Valid) begin
                    if (rx_Data[7:4] == 4'h0) state_d = ST_HDR0;
                    else                      state_d = ST_REPLY;
                end else begin
                    state_d = ST_WAIT_ARG;
                end
            end
            ST_HDR0:  state_d = pend_q ? ST_HDR0  : ST_HDR1;
            ST_HDR1:  state_d = pend_q ? ST_HDR1  : ST_START;
            ST_START: state_d = pend_q ? ST_START : ST_ARMED;
            ST_ARMED: begin
                if (!reader_DumpCompleted) state_d = ST_STREAM;
                else if (timeout_s)        state_d = ST_REPLY;
                else                       state_d = ST_ARMED;
            end
            ST_STREAM: begin
                if (reader_DumpCompleted) state_d = ST_TRL0;
                else                      state_d = ST_STREAM;
            end
            ST_TRL0:  state_d = pend_q ? ST_TRL0  : ST_TRL1;
            ST_TRL1:  state_d = pend_q ? ST_TRL1  : ST_IDLE;
            ST_REPLY: state_d = pend_q ? ST_REPLY : ST_IDLE;
            default:  state_d = ST_RESYNC;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        pend_d      = pend_q & ~ctl_accept_s;
        pend_data_d = pend_data_q;
        start_d     = 1'b0;
        size_d      = size_q;
        error_d     = error_q;
        xor_d       = xor_q;
        cnt_d       = cnt_q;
        reply_d     = reply_q;
        busy_d      = (state_d != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (rx_Valid) begin
                    if (rx_Data == CMD_VERSION) begin
                        reply_d = VERSION;
                        error_d = 1'b0;
                    end else if (rx_Data == CMD_DUMP) begin
                        error_d = 1'b0;
                    end else begin
                        reply_d = RSP_ERR;
                    end
                end else begin
                    reply_d = reply_q;
                end
            end
            ST_WAIT_ARG: begin
                if (rx_Valid) begin
                    if (rx_Data[7:4] == 4'h0) begin
                        size_d = rx_Data[3:0];
                        xor_d  = 8'h00;
                        cnt_d  = {TIMEOUT_W{1'b0}};
                    end else begin
                        error_d = 1'b1;
                        reply_d = RSP_ERR;
                    end
                end else begin
                    size_d = size_q;
                end
            end
            ST_HDR0: begin
                if (!pend_q) begin
                    pend_d      = 1'b1;
                    pend_data_d = HDR_MAGIC;
                end else begin
                    pend_data_d = pend_data_q;
                end
            end
            ST_HDR1: begin
                if (!pend_q) begin
                    pend_d      = 1'b1;
                    pend_data_d = {4'h0, size_q};
                end else begin
                    pend_data_d = pend_data_q;
                end
            end
            ST_START: begin
                if (!pend_q) begin
                    start_d = 1'b1;
                    cnt_d   = {TIMEOUT_W{1'b0}};
                end else begin
                    start_d = 1'b0;
                end
            end
            ST_ARMED: begin
                if (reader_DumpCompleted && timeout_s) begin
                    error_d = 1'b1;
                    reply_d = RSP_ERR;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            ST_STREAM: begin
                if (reader_Send) xor_d = xor_q ^ reader_Data;
                else             xor_d = xor_q;
            end
            ST_TRL0: begin
                if (!pend_q) begin
                    pend_d      = 1'b1;
                    pend_data_d = TRL_MAGIC;
                end else begin
                    pend_data_d = pend_data_q;
                end
            end
            ST_TRL1: begin
                if (!pend_q) begin
                    pend_d      = 1'b1;
                    pend_data_d = xor_q;
                end else begin
                    pend_data_d = pend_data_q;
                end
            end
            ST_REPLY: begin
                if (!pend_q) begin
                    pend_d      = 1'b1;
                    pend_data_d = reply_q;
                end else begin
                    pend_data_d = pend_data_q;
                end
            end
            default: begin
                pend_d = 1'b0;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q      <= 1'b0;
            pend_data_q <= 8'h00;
            start_q     <= 1'b0;
            size_q      <= 4'h0;
            error_q     <= 1'b0;
            xor_q       <= 8'h00;
            cnt_q       <= {TIMEOUT_W{1'b0}};
            reply_q     <= 8'h00;
            busy_q      <= 1'b1;
        end else begin
            pend_q      <= pend_d;
            pend_data_q <= pend_data_d;
            start_q     <= start_d;
            size_q      <= size_d;
            error_q     <= error_d;
            xor_q       <= xor_d;
            cnt_q       <= cnt_d;
            reply_q     <= reply_d;
            busy_q      <= busy_d;
        end
    end

    assign reader_StartDump     = start_q;
    assign reader_CartridgeSize = size_q;
    assign error                = error_q;
    assign busy                 = busy_q;

endmodule

// File: tb/tb_gba_dump_controller.sv
// Directed bench for gba_dump_controller with a behavioural pak-reader model and a TX byte monitor.
module tb_gba_dump_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_Data = 8'h00;
    logic       rx_Valid = 1'b0;
    logic [7:0] tx_Data;
    logic       tx_Send;
    logic       tx_IsReady = 1'b1;
    logic [3:0] reader_CartridgeSize;
    logic       reader_StartDump;
    logic       reader_DumpCompleted = 1'b1;
    logic [7:0] reader_Data = 8'h11;
    logic       reader_Send = 1'b0;
    logic       reader_IsReady;
    logic       busy;
    logic       error;

    int vec = 0;
    int miss = 0;

    int rd_len = 0;
    int rd_rem = 0;
    bit rd_active = 1'b0;
    bit rd_hang = 1'b0;
    bit rd_ignore = 1'b0;
    bit rdy_toggle = 1'b0;
    int tog_cnt = 0;

    logic [7:0] txq[$];
    int starts = 0;
    int viol = 0;
    bit watch = 1'b0;

    gba_dump_controller dut (
        .clk                  (clk),
        .rst                  (rst),
        .rx_Data              (rx_Data),
        .rx_Valid             (rx_Valid),
        .tx_Data              (tx_Data),
        .tx_Send              (tx_Send),
        .tx_IsReady           (tx_IsReady),
        .reader_CartridgeSize (reader_CartridgeSize),
        .reader_StartDump     (reader_StartDump),
        .reader_DumpCompleted (reader_DumpCompleted),
        .reader_Data          (reader_Data),
        .reader_Send          (reader_Send),
        .reader_IsReady       (reader_IsReady),
        .busy                 (busy),
        .error                (error)
    );

    always #5 clk = ~clk;

    // TX ready generator: steady high, or toggling every 3 cycles
    always @(posedge clk) begin
        #1;
        if (rdy_toggle) begin
            tog_cnt++;
            if (tog_cnt == 3) begin
                tog_cnt = 0;
                tx_IsReady = ~tx_IsReady;
            end
        end else begin
            tog_cnt = 0;
            tx_IsReady = 1'b1;
        end
    end

    // Reader model: one byte per cycle while allowed, completion after the last byte
    always @(negedge clk) begin
        if (reader_Send) rd_rem--;
        if (rd_active && rd_rem == 0) begin
            rd_active = 1'b0;
            reader_DumpCompleted = 1'b1;
        end
        if (reader_StartDump && !rd_hang) begin
            rd_active = 1'b1;
            rd_rem = rd_len;
            reader_DumpCompleted = 1'b0;
        end
        reader_Send = rd_active && (rd_rem > 0) && (reader_IsReady || rd_ignore);
        reader_Data = 8'h11;
    end

    // Monitor sampled just before each rising edge
    always @(negedge clk) begin
        #3;
        if (tx_Send) txq.push_back(tx_Data);
        if (reader_StartDump) starts++;
        if (watch && (tx_Send || reader_IsReady)) viol++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] qat(input int i);
        logic [31:0] r;
        if (i < txq.size()) r = {24'h0, txq[i]};
        else                r = 32'hDEAD;
        return r;
    endfunction

    task automatic rx_byte(input logic [7:0] b);
        @(negedge clk);
        rx_Data  = b;
        rx_Valid = 1'b1;
        @(negedge clk);
        rx_Valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        chk(tag, {31'h0, done}, 32'h1);
        repeat (8) @(negedge clk);
    endtask

    task automatic dump_192(input string tag);
        int bad;
        starts = 0;
        txq.delete();
        rd_len = 192;
        rx_byte(8'h44);
        rx_byte(8'h00);
        wait_idle(4000, {tag, "_idle"});
        chk({tag, "_len"}, txq.size(), 32'd196);
        chk({tag, "_hdr0"}, qat(0), 32'hA5);
        chk({tag, "_hdr1"}, qat(1), 32'h00);
        bad = 0;
        for (int i = 2; i < 194; i++) if (qat(i) !== 32'h11) bad++;
        chk({tag, "_data_bad"}, bad, 32'd0);
        chk({tag, "_trl0"}, qat(194), 32'h5A);
        chk({tag, "_trl1"}, qat(195), 32'h00);
        chk({tag, "_starts"}, starts, 32'd1);
    endtask

    initial begin
        bit got;
        repeat (3) @(negedge clk);
        chk("rst_tx_send", {31'h0, tx_Send}, 32'h0);
        chk("rst_tx_data", {24'h0, tx_Data}, 32'h00);
        chk("rst_start", {31'h0, reader_StartDump}, 32'h0);
        chk("rst_size", {28'h0, reader_CartridgeSize}, 32'h0);
        chk("rst_error", {31'h0, error}, 32'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("resync_to_idle", {31'h0, busy}, 32'h0);

        // Version command
        txq.delete();
        rx_byte(8'h56);
        wait_idle(50, "v_idle");
        chk("v_len", txq.size(), 32'd1);
        chk("v_byte", qat(0), 32'h01);
        chk("v_busy", {31'h0, busy}, 32'h0);

        // Full dump, steady ready, then with ready toggling
        dump_192("dump");
        chk("dump_size", {28'h0, reader_CartridgeSize}, 32'h0);
        rdy_toggle = 1'b1;
        dump_192("dump_tog");
        rdy_toggle = 1'b0;
        repeat (3) @(negedge clk);

        // Bad size argument, then error cleared by a valid command
        starts = 0;
        txq.delete();
        rx_byte(8'h44);
        rx_byte(8'h13);
        wait_idle(50, "badarg_idle");
        chk("badarg_len", txq.size(), 32'd1);
        chk("badarg_byte", qat(0), 32'h45);
        chk("badarg_error", {31'h0, error}, 32'h1);
        chk("badarg_starts", starts, 32'd0);
        txq.delete();
        rx_byte(8'h56);
        wait_idle(50, "clr_idle");
        chk("clr_byte", qat(0), 32'h01);
        chk("clr_error", {31'h0, error}, 32'h0);

        // Unknown command
        txq.delete();
        rx_byte(8'h33);
        wait_idle(50, "unk_idle");
        chk("unk_byte", qat(0), 32'h45);

        // Start timeout: reader never leaves completed
        rd_hang = 1'b1;
        starts = 0;
        txq.delete();
        rx_byte(8'h44);
        rx_byte(8'h01);
        repeat (900) @(negedge clk);
        chk("to_early_len", txq.size(), 32'd2);
        chk("to_early_busy", {31'h0, busy}, 32'h1);
        chk("to_early_error", {31'h0, error}, 32'h0);
        wait_idle(600, "to_idle");
        chk("to_len", txq.size(), 32'd3);
        chk("to_hdr1", qat(1), 32'h01);
        chk("to_byte", qat(2), 32'h45);
        chk("to_error", {31'h0, error}, 32'h1);
        chk("to_size", {28'h0, reader_CartridgeSize}, 32'h1);
        chk("to_starts", starts, 32'd1);
        rd_hang = 1'b0;

        // Reset in the middle of a stream; reader keeps going on its own
        txq.delete();
        rd_len = 60;
        rx_byte(8'h44);
        rx_byte(8'h00);
        got = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (txq.size() >= 12) begin
                got = 1'b1;
                break;
            end
        end
        chk("mid_stream_reached", {31'h0, got}, 32'h1);
        rd_ignore = 1'b1;
        watch = 1'b1;
        viol = 0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("resync_busy", {31'h0, busy}, 32'h1);
        wait_idle(500, "resync_idle");
        watch = 1'b0;
        rd_ignore = 1'b0;
        chk("resync_viol", viol, 32'd0);
        txq.delete();
        rx_byte(8'h56);
        wait_idle(50, "post_idle");
        chk("post_len", txq.size(), 32'd1);
        chk("post_byte", qat(0), 32'h01);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
